branch_predictor: RTL and testbench
===================================

# branch_predictor

Two-bit saturating-counter branch predictor with a tagless target table, the consumer end of the branch comparator's `o_br_less`/`o_br_equal` flags.
- **IF stage:** predicts taken/not-taken and the target for the fetch PC.
- **EX stage:** resolves the branch from funct3 and the comparator flags, and drives the comparator's unsigned-mode select. It flags mispredicts with the correct redirect PC, trains the table and keeps branch/mispredict statistics.

## Interface
Parameters:
- `INDEX_W`, default 6, number of table index bits. Table depth is 2^INDEX_W entries.

Ports:
- `i_clk`, input, 1: single clock. All state updates on the rising edge.
- `i_reset`, input, 1: synchronous, active-high reset.
- `i_if_pc`, input, 32: fetch PC to look up.
- `o_pred_taken`, output, 1: prediction for `i_if_pc`.
- `o_pred_target`, output, 32: predicted target, `{target[29:0], 2'b00}`.
- `i_ex_valid`, input, 1: EX slot holds a real instruction this cycle.
- `i_ex_is_br`, input, 1: EX instruction is a conditional branch.
- `i_ex_funct3`, input, 3: branch funct3.
- `i_ex_pc`, input, 32: PC of the EX instruction.
- `i_ex_target`, input, 32: computed branch target.
- `i_ex_pred_taken`, input, 1: prediction carried down the pipeline from IF.
- `i_ex_pred_target`, input, 32: predicted target carried down the pipeline from IF.
- `i_br_less`, input, 1: comparator less-than result.
- `i_br_equal`, input, 1: comparator equal result.
- `o_br_un`, output, 1: comparator mode select, 1 = unsigned compare.
- `o_ex_taken`, output, 1: resolved branch outcome.
- `o_mispredict`, output, 1: prediction was wrong; IF/ID must be flushed.
- `o_redirect_pc`, output, 32: correct next PC when `o_mispredict` is high.
- `o_br_count`, output, 32: number of resolved branches.
- `o_miss_count`, output, 32: number of mispredicts.

## Operation
Table entries, indexed by `pc[INDEX_W+1:2]`: 2-bit counter `ctr`, valid bit `v`, 30-bit target `tgt`.

Lookup (combinational):
- `o_pred_taken = v & ctr[1]`.
- `o_pred_target = {tgt, 2'b00}`.

Comparator mode:
- `o_br_un = 1` iff funct3 is 110 or 111, otherwise 0.
- Computed from `i_ex_funct3` alone, not gated by valid.

Outcome by funct3:
- 000 (BEQ): taken = `equal`.
- 001 (BNE): taken = `!equal`.
- 100 (BLT): taken = `less`.
- 101 (BGE): taken = `!less`.
- 110 (BLTU): taken = `less`.
- 111 (BGEU): taken = `!less`.
- 010/011: outcome is not-taken and the slot is excluded from the active resolve `res`. No table or counter update for these codes.

Active resolve: `res = i_ex_valid & i_ex_is_br & legal funct3`. When `res = 0`:
- `o_ex_taken = 0`, `o_mispredict = 0`.
- No state changes except reset.

Mispredict (when `res = 1`):
- `o_mispredict = (taken != i_ex_pred_taken) | (taken & i_ex_pred_taken & (i_ex_target != i_ex_pred_target))`.
- `o_redirect_pc = taken ? i_ex_target : i_ex_pc + 4`, computed modulo 2^32, so PC 0xFFFF_FFFC wraps to 0.

Training on `res`, at the next edge, for the entry indexed by `i_ex_pc`:
- Taken: `ctr` saturates up (3 stays 3), `v <= 1`, `tgt <= i_ex_target[31:2]`.
- Not taken: `ctr` saturates down (0 stays 0); `v` and `tgt` are unchanged.

Aliasing:
- No tags. PCs sharing an index share an entry by design.

Statistics:
- `o_br_count` increments on `res`.
- `o_miss_count` increments on `res & o_mispredict`.
- Both wrap from 0xFFFF_FFFF to 0.

Each branch is presented with `i_ex_valid` high for exactly one cycle. The pipeline deasserts it on stall repeats and bubbles.

## Timing
- **Lookup:** zero-latency combinational read of the registered table.
- **Resolve:** `o_ex_taken`, `o_mispredict`, `o_redirect_pc`, `o_br_un` are combinational from EX inputs in the same cycle.
- **Training:** table and counter writes take effect at the rising edge ending the resolve cycle. They are first visible to a lookup in the following cycle.
- **Same-index read/write in one cycle:** the lookup returns the pre-update value; there is no write-through bypass.
- **Reset (`i_reset` high at an edge):** every `ctr` becomes 01, every `v` becomes 0, every `tgt` becomes 0, both counts become 0.
  - After reset: `o_pred_taken = 0`, `o_pred_target = 0`.
  - Reset has priority over a simultaneous resolve, so that resolve is dropped.
  - Combinational EX outputs still follow their inputs while reset is held.

## Test plan
- **Reset:** assert reset mid-training with a resolve active in the same cycle → next cycle lookup of any PC gives `o_pred_taken = 0`, `o_pred_target = 0`, counts 0, and the resolve has no effect.
- **Loop training:** BLT at PC 0x100 to 0x80, `less = 1`, three resolves with `pred_taken` carried from lookup:
  - Mispredicts: yes, no, no.
  - Predictions after each resolve: 1, 1, 1.
  - Then a not-taken resolve → `o_mispredict = 1`, `o_redirect_pc = 0x104`, `ctr = 10`, prediction stays 1.
- **Target mismatch:** BEQ `equal = 1`, `pred_taken = 1`, `pred_target = 0x200`, target 0x240 → `o_mispredict = 1`, redirect 0x240, entry `tgt` updated to 0x240.
- **Comparator mode and illegal funct3:**
  - funct3 110 → `o_br_un = 1`; funct3 101 → 0.
  - funct3 010 with valid → `o_ex_taken = 0`, no mispredict, `o_br_count` unchanged.
- **Same-cycle aliasing:** lookup 0x1100 while resolving taken at 0x0100 (`INDEX_W = 6`, same index) → that cycle shows the old prediction, the next cycle shows the updated one.
- **Counter wrap:** force/preload `o_br_count` to 0xFFFF_FFFF, resolve once → 0.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Fetch-lookup, execute-resolve and statistics signals of the branch predictor.
// The DUT uses the slave modport; the pipeline or bench drives through master.
interface branch_predictor_if;
    logic [31:0] i_if_pc;
    logic        o_pred_taken;
    logic [31:0] o_pred_target;
    logic        i_ex_valid;
    logic        i_ex_is_br;
    logic [2:0]  i_ex_funct3;
    logic [31:0] i_ex_pc;
    logic [31:0] i_ex_target;
    logic        i_ex_pred_taken;
    logic [31:0] i_ex_pred_target;
    logic        i_br_less;
    logic        i_br_equal;
    logic        o_br_un;
    logic        o_ex_taken;
    logic        o_mispredict;
    logic [31:0] o_redirect_pc;
    logic [31:0] o_br_count;
    logic [31:0] o_miss_count;

    modport slave (
        input  i_if_pc, i_ex_valid, i_ex_is_br, i_ex_funct3, i_ex_pc, i_ex_target,
               i_ex_pred_taken, i_ex_pred_target, i_br_less, i_br_equal,
        output o_pred_taken, o_pred_target, o_br_un, o_ex_taken, o_mispredict,
               o_redirect_pc, o_br_count, o_miss_count
    );

    modport master (
        output i_if_pc, i_ex_valid, i_ex_is_br, i_ex_funct3, i_ex_pc, i_ex_target,
               i_ex_pred_taken, i_ex_pred_target, i_br_less, i_br_equal,
        input  o_pred_taken, o_pred_target, o_br_un, o_ex_taken, o_mispredict,
               o_redirect_pc, o_br_count, o_miss_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Two-bit saturating-counter predictor with a tagless target table: IF lookup,
// EX resolve against comparator flags, training and mispredict statistics.
module branch_predictor #(
    parameter int INDEX_W = 6
) (
    input logic            i_clk,
    input logic            i_reset,
    branch_predictor_if.slave bp
);
    localparam int DEPTH = 1 << INDEX_W;

    logic [DEPTH-1:0][1:0]  ctr;
    logic [DEPTH-1:0]       v;
    logic [DEPTH-1:0][29:0] tgt;
    logic [31:0]            br_count;
    logic [31:0]            miss_count;

    logic [INDEX_W-1:0] if_idx;
    logic [INDEX_W-1:0] ex_idx;
    logic               legal;
    logic               cond;
    logic               res;
    logic               taken;
    logic               mispredict;

    assign if_idx = bp.i_if_pc[INDEX_W+1:2];
    assign ex_idx = bp.i_ex_pc[INDEX_W+1:2];

    // Lookup reads the registered table only, so a same-cycle write is not seen.
    assign bp.o_pred_taken  = v[if_idx] & ctr[if_idx][1];
    assign bp.o_pred_target = {tgt[if_idx], 2'b00};

    assign bp.o_br_un = (bp.i_ex_funct3[2:1] == 2'b11);

    always_comb begin
        legal = 1'b1;
        cond  = 1'b0;
        case (bp.i_ex_funct3)
            3'b000:  cond = bp.i_br_equal;
            3'b001:  cond = !bp.i_br_equal;
            3'b100:  cond = bp.i_br_less;
            3'b101:  cond = !bp.i_br_less;
            3'b110:  cond = bp.i_br_less;
            3'b111:  cond = !bp.i_br_less;
            default: legal = 1'b0;
        endcase
    end

    assign res   = bp.i_ex_valid & bp.i_ex_is_br & legal;
    assign taken = res & cond;

    // A taken branch that was predicted taken can still miss on the target.
    assign mispredict = res & ((taken != bp.i_ex_pred_taken) |
                               (taken & bp.i_ex_pred_taken &
                                (bp.i_ex_target != bp.i_ex_pred_target)));

    assign bp.o_ex_taken    = taken;
    assign bp.o_mispredict  = mispredict;
    assign bp.o_redirect_pc = taken ? bp.i_ex_target : bp.i_ex_pc + 32'd4;
    assign bp.o_br_count    = br_count;
    assign bp.o_miss_count  = miss_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr[i] <= 2'b01;
                v[i]   <= 1'b0;
                tgt[i] <= '0;
            end
            br_count   <= '0;
            miss_count <= '0;
        end else if (res) begin
            if (taken) begin
                if (ctr[ex_idx] != 2'b11)
                    ctr[ex_idx] <= ctr[ex_idx] + 2'd1;
                v[ex_idx]   <= 1'b1;
                tgt[ex_idx] <= bp.i_ex_target[31:2];
            end else if (ctr[ex_idx] != 2'b00) begin
                ctr[ex_idx] <= ctr[ex_idx] - 2'd1;
            end
            br_count <= br_count + 32'd1;
            if (mispredict)
                miss_count <= miss_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: table of combinational resolve vectors under reset, then
// hand-written sequences for training, aliasing, counter wrap and reset.
module tb_branch_predictor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;

    branch_predictor_if bp ();
    branch_predictor #(.INDEX_W(6)) dut (.i_clk(clk), .i_reset(rst), .bp(bp));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] target;
        logic [2:0]  f3;
        logic        less;
        logic        eq;
        logic        pt;
        logic [31:0] ptgt;
        logic        valid;
        logic        isbr;
        logic        e_taken;
        logic        e_mis;
        logic [31:0] e_redir;
        logic        e_un;
        logic        chk_redir;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [31:0] pc, input logic [31:0] target, input logic [2:0] f3,
                          input logic less, input logic eq, input logic pt, input logic [31:0] ptgt);
        bp.i_ex_valid       = 1'b1;
        bp.i_ex_is_br       = 1'b1;
        bp.i_ex_pc          = pc;
        bp.i_ex_target      = target;
        bp.i_ex_funct3      = f3;
        bp.i_br_less        = less;
        bp.i_br_equal       = eq;
        bp.i_ex_pred_taken  = pt;
        bp.i_ex_pred_target = ptgt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{32'h100, 32'h80,  3'b000, 0, 1, 0, 32'h0,   1, 1, 1, 1, 32'h80,  0, 1};
        vecs[1]  = '{32'h100, 32'h80,  3'b000, 0, 0, 0, 32'h0,   1, 1, 0, 0, 32'h104, 0, 1};
        vecs[2]  = '{32'h200, 32'h300, 3'b001, 0, 0, 1, 32'h300, 1, 1, 1, 0, 32'h300, 0, 1};
        vecs[3]  = '{32'h200, 32'h300, 3'b100, 1, 0, 1, 32'h304, 1, 1, 1, 1, 32'h300, 0, 1};
        vecs[4]  = '{32'h200, 32'h300, 3'b101, 1, 0, 1, 32'h300, 1, 1, 0, 1, 32'h204, 0, 1};
        vecs[5]  = '{32'h40,  32'h10,  3'b110, 0, 0, 0, 32'h0,   1, 1, 0, 0, 32'h44,  1, 1};
        vecs[6]  = '{32'h40,  32'h10,  3'b111, 0, 0, 0, 32'h0,   1, 1, 1, 1, 32'h10,  1, 1};
        vecs[7]  = '{32'h40,  32'h10,  3'b010, 1, 1, 0, 32'h0,   1, 1, 0, 0, 32'h0,   0, 0};
        vecs[8]  = '{32'h40,  32'h10,  3'b011, 1, 1, 1, 32'h10,  1, 1, 0, 0, 32'h0,   0, 0};
        vecs[9]  = '{32'h40,  32'h10,  3'b000, 0, 1, 0, 32'h0,   0, 1, 0, 0, 32'h0,   0, 0};
        vecs[10] = '{32'h40,  32'h10,  3'b110, 0, 1, 0, 32'h0,   1, 0, 0, 0, 32'h0,   1, 0};
        vecs[11] = '{32'hFFFF_FFFC, 32'h8, 3'b000, 0, 0, 1, 32'h8, 1, 1, 0, 1, 32'h0, 0, 1};

        bp.i_if_pc = 32'h100;
        bp.i_ex_valid = 0; bp.i_ex_is_br = 0; bp.i_ex_funct3 = 0; bp.i_ex_pc = 0;
        bp.i_ex_target = 0; bp.i_ex_pred_taken = 0; bp.i_ex_pred_target = 0;
        bp.i_br_less = 0; bp.i_br_equal = 0;

        // Combinational resolve while reset is held: outputs follow inputs, no training.
        tick();
        foreach (vecs[i]) begin
            set_ex(vecs[i].pc, vecs[i].target, vecs[i].f3, vecs[i].less, vecs[i].eq,
                   vecs[i].pt, vecs[i].ptgt);
            bp.i_ex_valid = vecs[i].valid;
            bp.i_ex_is_br = vecs[i].isbr;
            #1;
            chk($sformatf("vec%0d taken", i), 32'(bp.o_ex_taken), 32'(vecs[i].e_taken));
            chk($sformatf("vec%0d mispredict", i), 32'(bp.o_mispredict), 32'(vecs[i].e_mis));
            chk($sformatf("vec%0d br_un", i), 32'(bp.o_br_un), 32'(vecs[i].e_un));
            if (vecs[i].chk_redir)
                chk($sformatf("vec%0d redirect", i), bp.o_redirect_pc, vecs[i].e_redir);
        end
        bp.i_ex_valid = 0;
        tick();
        rst = 0;
        #1;
        chk("reset pred_taken", 32'(bp.o_pred_taken), 0);
        chk("reset pred_target", bp.o_pred_target, 0);
        chk("reset br_count", bp.o_br_count, 0);
        chk("reset miss_count", bp.o_miss_count, 0);

        // Loop training: BLT at 0x100 to 0x80, prediction carried from lookup.
        for (int k = 0; k < 3; k++) begin
            bp.i_if_pc = 32'h100;
            #1;
            set_ex(32'h100, 32'h80, 3'b100, 1, 0, bp.o_pred_taken, bp.o_pred_target);
            #1;
            chk($sformatf("loop%0d mispredict", k), 32'(bp.o_mispredict), (k == 0) ? 1 : 0);
            tick();
            bp.i_ex_valid = 0;
            #1;
            chk($sformatf("loop%0d pred", k), 32'(bp.o_pred_taken), 1);
            chk($sformatf("loop%0d pred_target", k), bp.o_pred_target, 32'h80);
        end
        set_ex(32'h100, 32'h80, 3'b100, 0, 0, bp.o_pred_taken, bp.o_pred_target);
        #1;
        chk("exit mispredict", 32'(bp.o_mispredict), 1);
        chk("exit redirect", bp.o_redirect_pc, 32'h104);
        tick();
        bp.i_ex_valid = 0;
        #1;
        chk("exit pred stays", 32'(bp.o_pred_taken), 1);
        chk("br_count after loop", bp.o_br_count, 4);
        chk("miss_count after loop", bp.o_miss_count, 2);
        // Second not-taken drops ctr from 10 to 01, target kept.
        set_ex(32'h100, 32'h80, 3'b100, 0, 0, 1, 32'h80);
        tick();
        bp.i_ex_valid = 0;
        #1;
        chk("weak not-taken pred", 32'(bp.o_pred_taken), 0);
        chk("target kept", bp.o_pred_target, 32'h80);

        // Target mismatch on BEQ.
        set_ex(32'h40, 32'h240, 3'b000, 0, 1, 1, 32'h200);
        #1;
        chk("tgt mismatch mispredict", 32'(bp.o_mispredict), 1);
        chk("tgt mismatch redirect", bp.o_redirect_pc, 32'h240);
        tick();
        bp.i_ex_valid = 0;
        bp.i_if_pc = 32'h40;
        #1;
        chk("tgt updated", bp.o_pred_target, 32'h240);
        chk("tgt pred", 32'(bp.o_pred_taken), 1);
        chk("miss_count after tgt", bp.o_miss_count, 4);

        // Illegal funct3 with valid: no count, no training.
        set_ex(32'h40, 32'h400, 3'b010, 1, 1, 0, 32'h0);
        #1;
        chk("illegal taken", 32'(bp.o_ex_taken), 0);
        chk("illegal mispredict", 32'(bp.o_mispredict), 0);
        tick();
        bp.i_ex_valid = 0;
        #1;
        chk("illegal br_count", bp.o_br_count, 6);
        chk("illegal tgt untouched", bp.o_pred_target, 32'h240);

        // Same-cycle aliasing: 0x1100 and 0x0100 share index 0.
        bp.i_if_pc = 32'h1100;
        set_ex(32'h100, 32'h300, 3'b000, 0, 1, 0, 32'h0);
        #1;
        chk("alias old pred", 32'(bp.o_pred_taken), 0);
        chk("alias old target", bp.o_pred_target, 32'h80);
        tick();
        bp.i_ex_valid = 0;
        #1;
        chk("alias new pred", 32'(bp.o_pred_taken), 1);
        chk("alias new target", bp.o_pred_target, 32'h300);
        chk("alias br_count", bp.o_br_count, 7);
        chk("alias miss_count", bp.o_miss_count, 5);

        // Counter wrap from preloaded all-ones.
        force dut.br_count = 32'hFFFF_FFFF;
        #1;
        release dut.br_count;
        set_ex(32'h80, 32'h100, 3'b000, 0, 1, 1, 32'h100);
        tick();
        bp.i_ex_valid = 0;
        #1;
        chk("br_count wrap", bp.o_br_count, 0);

        // Reset with a resolve in the same cycle drops the resolve.
        set_ex(32'h40, 32'h500, 3'b000, 0, 1, 0, 32'h0);
        rst = 1;
        tick();
        rst = 0;
        bp.i_ex_valid = 0;
        bp.i_if_pc = 32'h40;
        #1;
        chk("post-reset pred", 32'(bp.o_pred_taken), 0);
        chk("post-reset target", bp.o_pred_target, 0);
        chk("post-reset br_count", bp.o_br_count, 0);
        chk("post-reset miss_count", bp.o_miss_count, 0);
        bp.i_if_pc = 32'h100;
        #1;
        chk("post-reset target 0x100", bp.o_pred_target, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
